data_mem_lanes: RTL
===================

# data_mem_lanes

Parametrised byte-lane data memory for the MIPS pipeline MEM stage, succeeding the fixed 256-word, word-only data memory. It supports byte/halfword/word loads and stores with sign or zero extension and flags misaligned accesses. It replaces the single-cycle bulk reset clear with a sequential clear sweep so the array can map onto RAM. The word-view test tap used by the board-level display remains available.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, ≥4
- TEST_WORD, 84, word index exposed on test_value
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- write_enable  in  1  store strobe, sampled on rising edge
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend
- address  in  32  byte address; bits above log2(DEPTH)+1 ignored (wrap)
- write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- read_data  out  32  load data, combinational, right-aligned and extended
- misalign  out  1  combinational fault for the current access
- busy  out  1  clear sweep in progress
- test_value  out  16  bits [15:0] of word TEST_WORD

## Operation
- Word index = address[log2(DEPTH)+1:2]; lane = address[1:0]; little-endian (lane 0 = bits [7:0]).
- misalign = (size==01 & address[0]) | (size==10 & address[1:0]!=0) | (size==11).
- Load: byte → lane selected, bits [31:8] = sign_ext ? bit 7 : 0; half → lanes {1,0} or {3,2}, extend from bit 15; word → full word.
- Store: only addressed lanes written (byte: 1 lane, half: 2, word: 4); other lanes unchanged.
- misalign=1 → store suppressed, read_data=0.
- FSM states: CLEAR, READY.
  - Reset → CLEAR, clr_idx=0.
  - CLEAR: every edge writes mem[clr_idx]=0, clr_idx++; at clr_idx==DEPTH-1 → READY.
  - READY: stays until reset.
- In CLEAR: busy=1, write_enable ignored, read_data=0, misalign=0, test_value=0.

## Timing
- Reset values: busy=1, read_data=0, misalign=0, test_value=0, state CLEAR, clr_idx=0.
- Clear latency: busy falls after exactly DEPTH rising edges following reset_n deassertion; the first access is accepted on the next edge.
- Store: takes effect at the rising edge where write_enable=1, busy=0, misalign=0. A load to the same word in the following cycle sees new data.
- Load: zero-cycle combinational path from address/size/sign_ext to read_data and misalign.
- Same-cycle load and store to one address: read_data shows old contents until the edge (no bypass).
- Reset mid-clear or mid-operation: sweep restarts at index 0 and all contents are re-zeroed.
- Address wrap: byte address 4*DEPTH aliases word 0.

## Configuration
- DATAMEM_FAULT_STICKY_EN defined: adds output fault_sticky (1 bit, reset 0). It is set on any rising edge with busy=0 and misalign=1, whether write_enable is high or low. It is cleared only by reset_n.
- Undefined: the fault_sticky port is absent; no added logic.

## Test plan
- Reset release, DEPTH=256 → busy=1 for 256 edges, then 0; a word load at any address returns 0x00000000; test_value=0.
- Word store 0xDEADBEEF @0x150 (word 84) → test_value=0xBEEF; byte load @0x153 with sign_ext=1 → 0xFFFFFFDE; with sign_ext=0 → 0x000000DE.
- Byte store 0x7A @0x11 after word store 0x11223344 @0x10 → word load @0x10 = 0x11227A44; half load @0x12 with sign_ext=1 → 0x00001122.
- Half store @0x21, or word store @0x22 → misalign=1, memory unchanged, read_data=0; with macro defined, fault_sticky=1 until reset.
- Word stores issued while busy=1 → ignored; after clear completes, that word reads 0.
- Reset asserted 10 cycles after a store 0xCAFEF00D @0x0 → busy restarts for DEPTH cycles; word 0 then reads 0. Store @0x400 with DEPTH=256 → aliases word 0.

Source files
------------

// File: rtl/data_mem_lanes.sv
// data_mem_lanes: byte-lane MEM-stage data memory with sequential clear sweep; optional DATAMEM_FAULT_STICKY_EN adds fault_sticky
module data_mem_lanes #(
  parameter int DEPTH = 256,
  parameter int TEST_WORD = 84
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        write_enable,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misalign,
  output logic        busy,
  output logic [15:0] test_value
`ifdef DATAMEM_FAULT_STICKY_EN
  ,
  output logic        fault_sticky
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t          state_q;
  logic [AW-1:0]   clr_idx_q;
  logic            busy_q;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            mis;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     rw;
  logic [31:0]     ld;
  logic            unused_addr;
  assign idx = address[AW+1:2];
  assign lane = address[1:0];
  assign unused_addr = ^address[31:AW+2];
  assign mis = (size == 2'b01 & lane[0]) | (size == 2'b10 & lane != 2'b00) | (size == 2'b11);
  assign be = size == 2'b00 ? 4'b0001 << lane : size == 2'b01 ? 4'b0011 << lane : 4'b1111;
  assign wd = write_data << {lane, 3'b000};
  assign rw = mem_q[idx] >> {lane, 3'b000};
  assign ld = size == 2'b00 ? {{24{sign_ext & rw[7]}}, rw[7:0]} :
              size == 2'b01 ? {{16{sign_ext & rw[15]}}, rw[15:0]} : rw;
  assign read_data = (busy_q | mis) ? '0 : ld;
  assign misalign = ~busy_q & mis;
  assign busy = busy_q;
  assign test_value = busy_q ? '0 : mem_q[TEST_WORD][15:0];
  // Clear sweep controller: walks every word once after reset, then stays ready
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      clr_idx_q <= '0;
      busy_q <= 1'b1;
    end else if (state_q == CLEAR) begin
      clr_idx_q <= clr_idx_q + AW'(1);
      if (clr_idx_q == AW'(DEPTH - 1)) begin
        state_q <= READY;
        busy_q <= 1'b0;
      end
    end
  end
  // Array writes: zero sweep while clearing, lane-masked stores once ready
  always_ff @(posedge clock) begin
    if (state_q == CLEAR) mem_q[clr_idx_q] <= '0;
    else if (write_enable && !mis)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
  end
`ifdef DATAMEM_FAULT_STICKY_EN
  logic fault_sticky_q;
  assign fault_sticky = fault_sticky_q;
  // Latches any misaligned access seen while ready until the next reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fault_sticky_q <= 1'b0;
    else if (!busy_q && mis) fault_sticky_q <= 1'b1;
  end
`endif
endmodule
